cdb_arbiter: RTL and testbench

Completion-side driver of the common data bus (CDB). Functional units (ALU, LD, ST, FP1, FP2) report finished instructions by destination tag. The block buffers each report in a small per-unit queue and grants one report per cycle by round-robin. It broadcasts the winner as a registered TAG that reservation stations, the map table and the ROB snoop to wake up dependents. It is the transmitter side of the tag-broadcast protocol that the reservation station consumes.

---
 rtl/cdb_arbiter.sv | 132 +++++++++++++
 tb/tb_cdb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdb_arbiter: per-unit completion queues, round-robin grant, registered CDB |
// | tag broadcast for wakeup of RS / map table / ROB.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package cdb_pkg;
  localparam int TAG_W = 6;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             ready;
    logic             valid;
  } TAG;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU  = 5,
  parameter int Q_DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [NUM_FU-1:0]         fu_done,
  input  TAG   [NUM_FU-1:0]         fu_tag,
  output logic [NUM_FU-1:0]         fu_stall,
  output TAG                        cdb,
  output logic [$clog2(NUM_FU)-1:0] cdb_fu
);

  localparam int FU_W  = $clog2(NUM_FU);
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = $clog2(Q_DEPTH + 1);

  logic [NUM_FU-1:0] w_req;
  logic [TAG_W-1:0]  w_head_tag [NUM_FU];
  logic [NUM_FU-1:0] w_unused_ready;
  logic              w_grant_valid;
  logic [FU_W-1:0]   w_grant;
  logic [FU_W:0]     w_scan;
  logic [FU_W-1:0]   r_rr_ptr;
  TAG                r_cdb;
  logic [FU_W-1:0]   r_cdb_fu;

  genvar i;
  generate
    for (i = 0; i < NUM_FU; i++) begin : g_fifo
      logic [TAG_W-1:0] r_mem [Q_DEPTH];
      logic [PTR_W-1:0] r_head;
      logic [PTR_W-1:0] r_tail;
      logic [CNT_W-1:0] r_count;
      logic             w_full;
      logic             w_enq;
      logic             w_deq;

      assign w_full        = (r_count == CNT_W'(Q_DEPTH));
      // Tagless completions (stores) are consumed here and never reach the bus.
      assign w_enq         = fu_done[i] && fu_tag[i].valid && !w_full;
      assign w_deq         = w_grant_valid && (w_grant == FU_W'(i));
      assign w_req[i]      = (r_count != '0);
      assign w_head_tag[i] = r_mem[r_head];
      assign fu_stall[i]   = w_full;
      assign w_unused_ready[i] = fu_tag[i].ready;

      always_ff @(posedge clock) begin
        if (reset || squash) begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
        end else begin
          if (w_enq) begin
            r_mem[r_tail] <= fu_tag[i].tag;
            r_tail        <= r_tail + PTR_W'(1);
          end
          if (w_deq) begin
            r_head <= r_head + PTR_W'(1);
          end
          if (w_enq && !w_deq) begin
            r_count <= r_count + CNT_W'(1);
          end else if (!w_enq && w_deq) begin
            r_count <= r_count - CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  // First non-empty queue at or after the round-robin pointer, wrapping.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_scan        = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (FU_W+1)'(k);
      if (w_scan >= (FU_W+1)'(NUM_FU)) begin
        w_scan = w_scan - (FU_W+1)'(NUM_FU);
      end
      if (!w_grant_valid && w_req[w_scan[FU_W-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant       = w_scan[FU_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (!squash && w_grant_valid) begin
      r_rr_ptr <= (w_grant == FU_W'(NUM_FU - 1)) ? '0 : w_grant + FU_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash || !w_grant_valid) begin
      r_cdb    <= '0;
      r_cdb_fu <= '0;
    end else begin
      r_cdb.tag   <= w_head_tag[w_grant];
      r_cdb.ready <= 1'b1;
      r_cdb.valid <= 1'b1;
      r_cdb_fu    <= w_grant;
    end
  end

  assign cdb    = r_cdb;
  assign cdb_fu = r_cdb_fu;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cdb_arbiter: directed self-checking bench for cdb_arbiter.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic           clock;
  logic           reset;
  logic           squash;
  logic [4:0]     fu_done;
  TAG   [4:0]     fu_tag;
  logic [4:0]     fu_stall;
  TAG             cdb;
  logic [2:0]     cdb_fu;

  int tests_run;
  int tests_failed;

  cdb_arbiter #(.NUM_FU(5), .Q_DEPTH(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .squash  (squash),
    .fu_done (fu_done),
    .fu_tag  (fu_tag),
    .fu_stall(fu_stall),
    .cdb     (cdb),
    .cdb_fu  (cdb_fu)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic TAG mk(input logic [TAG_W-1:0] t, input logic v);
    TAG r;
    r       = '0;
    r.tag   = t;
    r.valid = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fu_done = '0;
    fu_tag  = '0;
    squash  = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (cdb !== TAG'(0)) begin tests_failed++; $display("FAIL reset_cdb got=%h exp=0", cdb); end
    tests_run++;
    if (cdb_fu !== 3'd0) begin tests_failed++; $display("FAIL reset_cdb_fu got=%0d exp=0", cdb_fu); end
    tests_run++;
    if (fu_stall !== 5'b0) begin tests_failed++; $display("FAIL reset_stall got=%b exp=00000", fu_stall); end
  endtask

  task automatic test_single();
    do_reset();
    fu_done[0] = 1'b1;
    fu_tag[0]  = mk(6'd7, 1'b1);
    step();
    clear_inputs();
    tests_run++;
    if (cdb.valid !== 1'b0) begin tests_failed++; $display("FAIL single_c2_valid got=%b exp=0", cdb.valid); end
    step();
    tests_run++;
    if (cdb !== mk(6'd7, 1'b1) + TAG'(2)) begin tests_failed++; $display("FAIL single_c3_cdb got=%h exp=tag7 ready1 valid1", cdb); end
    tests_run++;
    if (cdb_fu !== 3'd0) begin tests_failed++; $display("FAIL single_c3_fu got=%0d exp=0", cdb_fu); end
    step();
    tests_run++;
    if (cdb.valid !== 1'b0) begin tests_failed++; $display("FAIL single_c4_valid got=%b exp=0", cdb.valid); end
  endtask

  task automatic test_contention();
    do_reset();
    fu_done = 5'b11111;
    for (int u = 0; u < 5; u++) fu_tag[u] = mk(TAG_W'(u + 1), 1'b1);
    step();
    clear_inputs();
    for (int u = 0; u < 5; u++) begin
      step();
      tests_run++;
      if (cdb.valid !== 1'b1 || cdb.tag !== TAG_W'(u + 1) || cdb_fu !== 3'(u)) begin
        tests_failed++;
        $display("FAIL contention_%0d got tag=%0d valid=%b fu=%0d exp tag=%0d valid=1 fu=%0d", u, cdb.tag, cdb.valid, cdb_fu, u + 1, u);
      end
    end
    step();
    tests_run++;
    if (cdb.valid !== 1'b0) begin tests_failed++; $display("FAIL contention_idle got valid=%b exp=0", cdb.valid); end
    // Pointer wrapped back to 0: ALU must beat FP2.
    fu_done = 5'b10001;
    fu_tag[0] = mk(6'd40, 1'b1);
    fu_tag[4] = mk(6'd41, 1'b1);
    step();
    clear_inputs();
    step();
    tests_run++;
    if (cdb_fu !== 3'd0 || cdb.tag !== 6'd40) begin tests_failed++; $display("FAIL contention_rr_wrap got fu=%0d tag=%0d exp fu=0 tag=40", cdb_fu, cdb.tag); end
    step();
    tests_run++;
    if (cdb_fu !== 3'd4 || cdb.tag !== 6'd41) begin tests_failed++; $display("FAIL contention_rr_next got fu=%0d tag=%0d exp fu=4 tag=41", cdb_fu, cdb.tag); end
    step();
  endtask

  task automatic test_fairness();
    logic [TAG_W-1:0] exp0[$];
    logic [TAG_W-1:0] exp4[$];
    logic [TAG_W-1:0] e;
    logic [TAG_W-1:0] na;
    logic [TAG_W-1:0] nb;
    logic             prev_valid;
    logic [2:0]       prev_fu;
    do_reset();
    na = 6'd1;
    nb = 6'd32;
    prev_valid = 1'b0;
    prev_fu = 3'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      fu_done = '0;
      if (cyc < 20) begin
        if (!fu_stall[0]) begin fu_done[0] = 1'b1; fu_tag[0] = mk(na, 1'b1); exp0.push_back(na); na++; end
        if (!fu_stall[4]) begin fu_done[4] = 1'b1; fu_tag[4] = mk(nb, 1'b1); exp4.push_back(nb); nb++; end
      end
      step();
      if (cdb.valid) begin
        tests_run++;
        if (cdb_fu == 3'd0 && exp0.size() > 0) begin
          e = exp0.pop_front();
          if (cdb.tag !== e) begin tests_failed++; $display("FAIL fair_alu_tag got=%0d exp=%0d", cdb.tag, e); end
        end else if (cdb_fu == 3'd4 && exp4.size() > 0) begin
          e = exp4.pop_front();
          if (cdb.tag !== e) begin tests_failed++; $display("FAIL fair_fp2_tag got=%0d exp=%0d", cdb.tag, e); end
        end else begin
          tests_failed++;
          $display("FAIL fair_unexpected got fu=%0d tag=%0d exp no broadcast", cdb_fu, cdb.tag);
        end
        if (cyc < 20 && prev_valid) begin
          tests_run++;
          if (cdb_fu !== ((prev_fu == 3'd0) ? 3'd4 : 3'd0)) begin
            tests_failed++;
            $display("FAIL fair_alternate got fu=%0d after fu=%0d", cdb_fu, prev_fu);
          end
        end
        prev_fu = cdb_fu;
      end
      prev_valid = cdb.valid;
    end
    clear_inputs();
    tests_run++;
    if (exp0.size() != 0) begin tests_failed++; $display("FAIL fair_alu_lost got remaining=%0d exp=0", exp0.size()); end
    tests_run++;
    if (exp4.size() != 0) begin tests_failed++; $display("FAIL fair_fp2_lost got remaining=%0d exp=0", exp4.size()); end
  endtask

  task automatic test_full_queue();
    do_reset();
    fu_done = 5'b00011;
    fu_tag[0] = mk(6'd40, 1'b1);
    fu_tag[1] = mk(6'd10, 1'b1);
    step();
    fu_done = 5'b00010;
    fu_tag[1] = mk(6'd11, 1'b1);
    step();
    tests_run++;
    if (cdb.tag !== 6'd40 || cdb_fu !== 3'd0) begin tests_failed++; $display("FAIL full_alu_first got fu=%0d tag=%0d exp fu=0 tag=40", cdb_fu, cdb.tag); end
    tests_run++;
    if (fu_stall !== 5'b00010) begin tests_failed++; $display("FAIL full_stall got=%b exp=00010", fu_stall); end
    fu_tag[1] = mk(6'd12, 1'b1);
    step();
    clear_inputs();
    tests_run++;
    if (cdb.valid !== 1'b1 || cdb.tag !== 6'd10 || cdb_fu !== 3'd1) begin tests_failed++; $display("FAIL full_first got valid=%b fu=%0d tag=%0d exp fu=1 tag=10", cdb.valid, cdb_fu, cdb.tag); end
    tests_run++;
    if (fu_stall !== 5'b0) begin tests_failed++; $display("FAIL full_unstall got=%b exp=00000", fu_stall); end
    step();
    tests_run++;
    if (cdb.valid !== 1'b1 || cdb.tag !== 6'd11 || cdb_fu !== 3'd1) begin tests_failed++; $display("FAIL full_second got valid=%b fu=%0d tag=%0d exp fu=1 tag=11", cdb.valid, cdb_fu, cdb.tag); end
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (cdb.valid !== 1'b0) begin tests_failed++; $display("FAIL full_dropped got valid=%b tag=%0d exp no broadcast", cdb.valid, cdb.tag); end
    end
  endtask

  task automatic test_store();
    do_reset();
    fu_done[2] = 1'b1;
    fu_tag[2]  = mk(6'd9, 1'b0);
    step();
    clear_inputs();
    tests_run++;
    if (fu_stall[2] !== 1'b0) begin tests_failed++; $display("FAIL store_stall got=%b exp=0", fu_stall[2]); end
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (cdb.valid !== 1'b0) begin tests_failed++; $display("FAIL store_bcast got valid=%b tag=%0d exp no broadcast", cdb.valid, cdb.tag); end
    end
  endtask

  // use_reset=0 flushes with squash (rr_ptr kept at 4), 1 flushes with reset (rr_ptr 0).
  task automatic test_flush(input logic use_reset);
    do_reset();
    fu_done[3] = 1'b1;
    fu_tag[3]  = mk(6'd30, 1'b1);
    step();
    clear_inputs();
    step();
    tests_run++;
    if (cdb.tag !== 6'd30 || cdb_fu !== 3'd3) begin tests_failed++; $display("FAIL flush%0d_pre got fu=%0d tag=%0d exp fu=3 tag=30", use_reset, cdb_fu, cdb.tag); end
    fu_done = 5'b01101;
    fu_tag[0] = mk(6'd21, 1'b1);
    fu_tag[2] = mk(6'd22, 1'b1);
    fu_tag[3] = mk(6'd23, 1'b1);
    step();
    fu_done = 5'b10000;
    fu_tag[4] = mk(6'd24, 1'b1);
    if (use_reset) reset = 1'b1; else squash = 1'b1;
    step();
    clear_inputs();
    tests_run++;
    if (cdb.valid !== 1'b0) begin tests_failed++; $display("FAIL flush%0d_cdb got valid=%b tag=%0d exp=0", use_reset, cdb.valid, cdb.tag); end
    tests_run++;
    if (fu_stall !== 5'b0) begin tests_failed++; $display("FAIL flush%0d_stall got=%b exp=00000", use_reset, fu_stall); end
    for (int c = 0; c < 4; c++) begin
      step();
      tests_run++;
      if (cdb.valid !== 1'b0) begin tests_failed++; $display("FAIL flush%0d_leak got tag=%0d fu=%0d exp no broadcast", use_reset, cdb.tag, cdb_fu); end
    end
    fu_done = 5'b10001;
    fu_tag[0] = mk(6'd50, 1'b1);
    fu_tag[4] = mk(6'd51, 1'b1);
    step();
    clear_inputs();
    step();
    tests_run++;
    if (use_reset) begin
      if (cdb_fu !== 3'd0 || cdb.tag !== 6'd50) begin tests_failed++; $display("FAIL flush1_rr got fu=%0d tag=%0d exp fu=0 tag=50", cdb_fu, cdb.tag); end
    end else begin
      if (cdb_fu !== 3'd4 || cdb.tag !== 6'd51) begin tests_failed++; $display("FAIL flush0_rr got fu=%0d tag=%0d exp fu=4 tag=51", cdb_fu, cdb.tag); end
    end
    step();
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_full_queue();
    test_store();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
